// File: rtl/common_pkg.sv
// Shared pipeline types: forwarding select, M-extension op encoding and M-unit FSM states.
package common;

    localparam int         XLEN_DEFAULT = 32;
    localparam logic [6:0] MD_FUNCT7    = 7'b0000001;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        EX_MEM  = 2'd1,
        MEM_WB  = 2'd2
    } forwarding_type;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_type;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_type;

endpackage

// File: rtl/execute_md_divider.sv
// Iterative restoring divider on unsigned magnitudes; resolves BITS quotient bits per cycle.
// o_done is high during the final iteration cycle; quotient/remainder are valid after that edge.
module md_divider #(
    parameter int XLEN = 32,
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);
    localparam int ITERS = XLEN / BITS;
    localparam int CW    = $clog2(ITERS + 1);

    logic [XLEN-1:0] r_quo, r_rem, r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;

    logic [XLEN-1:0] w_quo, w_rem;
    logic [XLEN:0]   w_trial;

    // NOTE: always_comb variables get a default before any branch so no latch is inferred.
    always_comb begin
        w_quo   = r_quo;
        w_rem   = r_rem;
        w_trial = '0;
        // NOTE: blocking assignments here chain BITS iterations within one cycle.
        for (int i = 0; i < BITS; i++) begin
            w_trial = {w_rem, w_quo[XLEN-1]} - {1'b0, r_div};
            if (!w_trial[XLEN]) begin
                w_rem = w_trial[XLEN-1:0];
                w_quo = {w_quo[XLEN-2:0], 1'b1};
            end else begin
                w_rem = {w_rem[XLEN-2:0], w_quo[XLEN-1]};
                w_quo = {w_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_quo  <= i_dividend;
            r_rem  <= '0;
            r_div  <= i_divisor;
            r_cnt  <= CW'(ITERS);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_quo <= w_quo;
            r_rem <= w_rem;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_busy <= 1'b0;
        end
    end

    assign o_done      = r_busy && (r_cnt == CW'(1));
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/execute_md.sv
// Multi-cycle RISC-V M-extension unit for EX, with forwarding select and pipeline stall.
// Optional: define EXECUTE_MD_RESULT_CACHE_EN to replay the last division's result in one cycle.
module execute_md
    import common::*;
#(
    parameter int XLEN               = XLEN_DEFAULT,
    parameter int MUL_STAGES         = 2,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_from_mem,
    input  logic [XLEN-1:0] i_from_wb,
    input  forwarding_type  i_fwd_a,
    input  forwarding_type  i_fwd_b,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            stall
);
    localparam logic [2:0]      S_IDLE  = ST_IDLE;
    localparam logic [2:0]      S_MUL   = ST_MUL;
    localparam logic [2:0]      S_DIV   = ST_DIV;
    localparam logic [2:0]      S_FIX   = ST_FIX;
    localparam logic [2:0]      S_DONE  = ST_DONE;
    localparam int              MCW     = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      r_state, r_funct3;
    logic [XLEN-1:0] r_a, r_b, r_result;
    logic [MCW-1:0]  r_mul_cnt;

    logic [XLEN-1:0] w_a, w_b, w_mag_a, w_mag_b;
    logic            w_accept, w_in_signed, w_in_special, w_div_start, w_hit;
    logic [XLEN-1:0] w_hit_result;

    assign w_a = (i_fwd_a == EX_MEM) ? i_from_mem : (i_fwd_a == MEM_WB) ? i_from_wb : i_rs1_data;
    assign w_b = (i_fwd_b == EX_MEM) ? i_from_mem : (i_fwd_b == MEM_WB) ? i_from_wb : i_rs2_data;

    assign w_accept     = (r_state == S_IDLE) && i_valid && !i_flush;
    assign w_in_signed  = !i_funct3[0];
    assign w_in_special = (w_b == '0) || (w_in_signed && (w_a == INT_MIN) && (w_b == '1));
    assign w_mag_a      = (w_in_signed && w_a[XLEN-1]) ? -w_a : w_a;
    assign w_mag_b      = (w_in_signed && w_b[XLEN-1]) ? -w_b : w_b;
    assign w_div_start  = w_accept && i_funct3[2] && !w_in_special && !w_hit;

    logic            w_div_done;
    logic [XLEN-1:0] w_div_quo, w_div_rem;

    md_divider #(.XLEN(XLEN), .BITS(DIV_BITS_PER_CYCLE)) u_divider (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_kill      (i_flush),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // Single multiplier on latched operands; the MUL state gives it MUL_STAGES cycles to settle.
    logic              w_mul_a_signed, w_mul_b_signed;
    logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_prod;
    logic [XLEN-1:0]   w_mul_result;

    assign w_mul_a_signed = (r_funct3 != MD_MULHU);
    assign w_mul_b_signed = (r_funct3 == MD_MUL) || (r_funct3 == MD_MULH);
    assign w_ext_a        = {{XLEN{w_mul_a_signed & r_a[XLEN-1]}}, r_a};
    assign w_ext_b        = {{XLEN{w_mul_b_signed & r_b[XLEN-1]}}, r_b};
    assign w_prod         = w_ext_a * w_ext_b;
    assign w_mul_result   = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    logic            w_signed, w_a_neg, w_b_neg, w_div_zero, w_ovf;
    logic [XLEN-1:0] w_fix_quo, w_fix_rem, w_fix_result;

    assign w_signed   = !r_funct3[0];
    assign w_a_neg    = w_signed & r_a[XLEN-1];
    assign w_b_neg    = w_signed & r_b[XLEN-1];
    assign w_div_zero = (r_b == '0);
    assign w_ovf      = w_signed && (r_a == INT_MIN) && (r_b == '1);

    always_comb begin
        w_fix_quo = w_div_quo;
        w_fix_rem = w_div_rem;
        if (w_div_zero) begin
            w_fix_quo = '1;
            w_fix_rem = r_a;
        end else if (w_ovf) begin
            w_fix_quo = r_a;
            w_fix_rem = '0;
        end else begin
            if (w_a_neg ^ w_b_neg) w_fix_quo = -w_div_quo;
            if (w_a_neg)           w_fix_rem = -w_div_rem;
        end
    end

    assign w_fix_result = r_funct3[1] ? w_fix_rem : w_fix_quo;

`ifdef EXECUTE_MD_RESULT_CACHE_EN
    logic            r_c_valid, r_c_signed;
    logic [XLEN-1:0] r_c_a, r_c_b, r_c_quo, r_c_rem;

    assign w_hit        = r_c_valid && i_funct3[2] && (w_a == r_c_a) && (w_b == r_c_b)
                          && (w_in_signed == r_c_signed);
    assign w_hit_result = i_funct3[1] ? r_c_rem : r_c_quo;

    // NOTE: the cache is a handful of flops, so it is reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
        end else if (i_flush && (r_state != S_IDLE) && r_funct3[2]) begin
            r_c_valid <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_c_valid  <= 1'b1;
            r_c_signed <= w_signed;
            r_c_a      <= r_a;
            r_c_b      <= r_b;
            r_c_quo    <= w_fix_quo;
            r_c_rem    <= w_fix_rem;
        end
    end
`else
    assign w_hit        = 1'b0;
    assign w_hit_result = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_funct3  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_mul_cnt <= '0;
        end else if (i_flush) begin
            r_state   <= S_IDLE;
            r_mul_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_valid) begin
                    r_a       <= w_a;
                    r_b       <= w_b;
                    r_funct3  <= i_funct3;
                    r_mul_cnt <= '0;
                    if (!i_funct3[2]) begin
                        r_state <= S_MUL;
                    end else if (w_hit) begin
                        r_state  <= S_DONE;
                        r_result <= w_hit_result;
                    end else if (w_in_special) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_MUL: begin
                    if (r_mul_cnt == MCW'(MUL_STAGES - 1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_mul_result;
                    end else begin
                        r_mul_cnt <= r_mul_cnt + 1'b1;
                    end
                end
                S_DIV: if (w_div_done) r_state <= S_FIX;
                S_FIX: begin
                    r_state  <= S_DONE;
                    r_result <= w_fix_result;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_valid  = (r_state == S_DONE) && !i_flush;
    assign o_result = r_result;
    assign stall    = w_accept || (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md at default parameters; define EXECUTE_MD_RESULT_CACHE_EN to expect cache hits.
module tb_execute_md;
    import common::*;

`ifdef EXECUTE_MD_RESULT_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 34;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_valid = 1'b0;
    logic [2:0]     i_funct3 = '0;
    logic [31:0]    i_rs1_data = '0, i_rs2_data = '0, i_from_mem = '0, i_from_wb = '0;
    forwarding_type i_fwd_a = FWD_REG, i_fwd_b = FWD_REG;
    logic           i_flush = 1'b0;
    logic           o_valid, stall;
    logic [31:0]    o_result;

    int tests_run = 0;
    int tests_failed = 0;

    execute_md dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_funct3   (i_funct3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_from_mem (i_from_mem),
        .i_from_wb  (i_from_wb),
        .i_fwd_a    (i_fwd_a),
        .i_fwd_b    (i_fwd_b),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drives one op starting in the current (IDLE) cycle; lat counts cycles from accept to o_valid.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input forwarding_type fa, input forwarding_type fb,
                            output int lat, output logic [31:0] res, output int stalls);
        lat = -1; res = 'x; stalls = 0;
        i_fwd_a    = fa;
        i_fwd_b    = fb;
        i_rs1_data = (fa == FWD_REG) ? a : 32'hDEAD_0001;
        i_rs2_data = (fb == FWD_REG) ? b : 32'hDEAD_0002;
        i_from_mem = (fa == EX_MEM) ? a : (fb == EX_MEM) ? b : 32'hDEAD_0003;
        i_from_wb  = (fa == MEM_WB) ? a : (fb == MEM_WB) ? b : 32'hDEAD_0004;
        i_funct3   = f3;
        i_valid    = 1'b1;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (stall) stalls++;
            if (o_valid) begin
                lat = c;
                res = o_result;
                break;
            end
            @(negedge clk);
            i_rs1_data = ~i_rs1_data;
            i_rs2_data = ~i_rs2_data;
            i_from_mem = ~i_from_mem;
            i_from_wb  = ~i_from_wb;
        end
        i_valid = 1'b0;
        i_fwd_a = FWD_REG;
        i_fwd_b = FWD_REG;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        tests_run++; if (o_result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", o_result); end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat, st; logic [31:0] res;
        @(negedge clk); issue_op(3'b000, 32'd7, -32'sd3, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_res: got %h want ffffffeb", res); end
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL mul_lat: got %0d want 3", lat); end
        tests_run++; if (st !== 3) begin tests_failed++; $display("FAIL mul_stall_cycles: got %0d want 3", st); end
        @(negedge clk); #1;
        tests_run++; if (o_valid !== 1'b0 || o_result !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_hold: valid %b result %h want 0 ffffffeb", o_valid, o_result); end
    endtask

    task automatic test_mulh();
        int lat, st; logic [31:0] res;
        @(negedge clk); issue_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mulhu_res: got %h want fffffffe", res); end
        @(negedge clk); issue_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mulhsu_res: got %h want ffffffff", res); end
        @(negedge clk); issue_op(3'b001, 32'h8000_0000, 32'h8000_0000, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'h4000_0000) begin tests_failed++; $display("FAIL mulh_res: got %h want 40000000", res); end
        @(negedge clk); issue_op(3'b000, 32'h0001_2345, 32'h0000_0100, EX_MEM, MEM_WB, lat, res, st);
        tests_run++; if (res !== 32'h0123_4500) begin tests_failed++; $display("FAIL fwd_mem_wb_res: got %h want 01234500", res); end
        @(negedge clk); issue_op(3'b000, 32'd9, 32'd11, MEM_WB, EX_MEM, lat, res, st);
        tests_run++; if (res !== 32'd99) begin tests_failed++; $display("FAIL fwd_wb_mem_res: got %h want 00000063", res); end
    endtask

    task automatic test_div();
        int lat, st; logic [31:0] res;
        @(negedge clk); issue_op(3'b100, -32'sd20, 32'd3, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hFFFF_FFFA) begin tests_failed++; $display("FAIL div_res: got %h want fffffffa", res); end
        tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL div_lat: got %0d want 34", lat); end
        tests_run++; if (st !== 34) begin tests_failed++; $display("FAIL div_stall_cycles: got %0d want 34", st); end
        @(negedge clk); issue_op(3'b110, -32'sd20, 32'd3, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL rem_res: got %h want fffffffe", res); end
        @(negedge clk); issue_op(3'b100, 32'd20, -32'sd3, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hFFFF_FFFA) begin tests_failed++; $display("FAIL div_negb_res: got %h want fffffffa", res); end
        @(negedge clk); issue_op(3'b110, 32'd20, -32'sd3, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'd2) begin tests_failed++; $display("FAIL rem_negb_res: got %h want 00000002", res); end
        @(negedge clk); issue_op(3'b111, 32'hFFFF_FFFF, 32'h10, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hF) begin tests_failed++; $display("FAIL remu_res: got %h want 0000000f", res); end
        @(negedge clk); issue_op(3'b101, 32'hFFFF_FFFF, 32'h10, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'h0FFF_FFFF) begin tests_failed++; $display("FAIL divu_res: got %h want 0fffffff", res); end
    endtask

    task automatic test_special();
        int lat, st; logic [31:0] res;
        @(negedge clk); issue_op(3'b101, 32'd1234, 32'd0, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divu_zero_res: got %h want ffffffff", res); end
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL divu_zero_lat: got %0d want 2", lat); end
        @(negedge clk); issue_op(3'b110, -32'sd5, 32'd0, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'hFFFF_FFFB) begin tests_failed++; $display("FAIL rem_zero_res: got %h want fffffffb", res); end
        @(negedge clk); issue_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_ovf_res: got %h want 80000000", res); end
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL div_ovf_lat: got %0d want 2", lat); end
        @(negedge clk); issue_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'h0) begin tests_failed++; $display("FAIL rem_ovf_res: got %h want 00000000", res); end
    endtask

    task automatic test_flush();
        int lat, st, seen; logic [31:0] res;
        @(negedge clk);
        i_funct3 = 3'b100; i_rs1_data = -32'sd20; i_rs2_data = 32'd3; i_valid = 1'b1;
        repeat (10) @(negedge clk);
        i_flush = 1'b1; #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL flush_stall_during: got %b want 1", stall); end
        @(negedge clk);
        i_flush = 1'b0; i_valid = 1'b0; #1;
        tests_run++; if (stall !== 1'b0 || o_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_after: stall %b valid %b want 0 0", stall, o_valid); end
        issue_op(3'b000, 32'd6, 32'd7, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'd42 || lat !== 3) begin tests_failed++; $display("FAIL flush_b2b_mul: got %h lat %0d want 0000002a lat 3", res, lat); end
        seen = 0;
        repeat (40) begin @(negedge clk); #1; if (o_valid) seen++; end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL flush_no_valid: got %0d pulses want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int lat, st; logic [31:0] res;
        @(negedge clk);
        i_funct3 = 3'b100; i_rs1_data = 32'd100; i_rs2_data = 32'd7; i_valid = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; #1;
        tests_run++; if (stall !== 1'b0 || o_valid !== 1'b0 || o_result !== 32'h0) begin tests_failed++; $display("FAIL rst_mid: stall %b valid %b result %h want 0 0 0", stall, o_valid, o_result); end
        @(negedge clk);
        rst = 1'b0;
        issue_op(3'b000, 32'd6, 32'd7, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'd42 || lat !== 3) begin tests_failed++; $display("FAIL rst_b2b_mul: got %h lat %0d want 0000002a lat 3", res, lat); end
    endtask

    task automatic test_flush_done();
        @(negedge clk);
        i_funct3 = 3'b000; i_rs1_data = 32'd3; i_rs2_data = 32'd5; i_valid = 1'b1;
        repeat (3) @(negedge clk);
        i_flush = 1'b1; #1;
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_done_valid: got %b want 0", o_valid); end
        i_valid = 1'b0;
        @(negedge clk);
        i_flush = 1'b0; #1;
        tests_run++; if (o_valid !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL flush_done_after: valid %b stall %b want 0 0", o_valid, stall); end
    endtask

    task automatic test_cache();
        int lat, st; logic [31:0] res;
        @(negedge clk); issue_op(3'b100, 32'd100, 32'd7, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'd14 || lat !== 34) begin tests_failed++; $display("FAIL cache_fill_div: got %h lat %0d want 0000000e lat 34", res, lat); end
        @(negedge clk); issue_op(3'b110, 32'd100, 32'd7, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'd2 || lat !== HIT_LAT) begin tests_failed++; $display("FAIL cache_hit_rem: got %h lat %0d want 00000002 lat %0d", res, lat, HIT_LAT); end
        tests_run++; if (st !== HIT_LAT) begin tests_failed++; $display("FAIL cache_hit_stall: got %0d want %0d", st, HIT_LAT); end
        @(negedge clk);
        i_funct3 = 3'b100; i_rs1_data = 32'd50; i_rs2_data = 32'd5; i_valid = 1'b1;
        repeat (5) @(negedge clk);
        i_flush = 1'b1; i_valid = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        issue_op(3'b110, 32'd100, 32'd7, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'd2 || lat !== 34) begin tests_failed++; $display("FAIL cache_after_flush: got %h lat %0d want 00000002 lat 34", res, lat); end
        @(negedge clk); issue_op(3'b111, 32'd100, 32'd7, FWD_REG, FWD_REG, lat, res, st);
        tests_run++; if (res !== 32'd2 || lat !== 34) begin tests_failed++; $display("FAIL cache_sign_miss: got %h lat %0d want 00000002 lat 34", res, lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_flush_done();
        test_cache();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
